// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO of DEPTH words (any DEPTH >= 2), with an occupancy count, almost-full/almost-empty
// flags and overflow/underflow pulses. FWFT selects registered-read or first-word-fall-through output.
module sync_fifo_ext #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned AFULL_LEVEL  = DEPTH - 1,
  parameter int unsigned AEMPTY_LEVEL = 1,
  parameter int unsigned FWFT         = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_val,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, wr_acc, rd_acc;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths use every entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full        = (count_q == CNT_FULL);
    empty       = (count_q == '0);
    wr_acc      = wr_en && !full;
    rd_acc      = rd_en && !empty;
    wr_ptr_d    = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_d = count_q - 1'b1;
    end
    overflow_d  = wr_en && full;
    underflow_d = rd_en && empty;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only discards it by rewinding the pointers.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign count        = count_q;
  assign wr_ready     = !full;
  assign almost_full  = (count_q >= CW'(AFULL_LEVEL));
  assign almost_empty = (count_q <= CW'(AEMPTY_LEVEL));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  if (FWFT == 0) begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_val_q, rd_val_d;

    always_comb begin
      rd_data_d = rd_data_q;
      if (rd_acc) begin
        rd_data_d = mem_q[rd_ptr_q];
      end
      rd_val_d = rd_acc;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q <= '0;
        rd_val_q  <= 1'b0;
      end else begin
        rd_data_q <= rd_data_d;
        rd_val_q  <= rd_val_d;
      end
    end

    assign rd_data = rd_data_q;
    assign rd_val  = rd_val_q;
  end else begin : g_fwft
    assign rd_data = mem_q[rd_ptr_q];
    assign rd_val  = !empty;
  end

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised single-clock FIFO, the general-purpose buffer for streaming datapaths inside the team's designs. It holds exactly DEPTH words for any DEPTH ≥ 2, including non-power-of-two values, and accepts a read and a write in the same cycle. It provides an occupancy count, programmable almost-full/almost-empty flags and overflow/underflow error pulses. A build-time mode selects either a registered read (one-cycle latency) or first-word-fall-through (FWFT) output.

## Interface
- DEPTH, 8, number of storage words; legal range ≥ 2.
- DATA_WIDTH, 8, width of the data words.
- AFULL_LEVEL, DEPTH-1, almost_full asserts when count ≥ AFULL_LEVEL.
- AEMPTY_LEVEL, 1, almost_empty asserts when count ≤ AEMPTY_LEVEL.
- FWFT, 0, output mode: 0 = registered read, 1 = first-word-fall-through.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- wr_ready  out  1  high when count < DEPTH.
- rd_en  in  1  read request (FWFT=0) or pop (FWFT=1).
- rd_data  out  DATA_WIDTH  read word.
- rd_val  out  1  rd_data valid.
- count  out  $clog2(DEPTH+1)  number of stored words.
- almost_full  out  1  count ≥ AFULL_LEVEL.
- almost_empty  out  1  count ≤ AEMPTY_LEVEL.
- overflow  out  1  one-cycle pulse when a write is dropped.
- underflow  out  1  one-cycle pulse when a read hits an empty FIFO.

## Operation
- Storage: DEPTH-entry array with write and read pointers, each in the range 0..DEPTH-1. A pointer at DEPTH-1 wraps to 0 on increment. No power-of-two arithmetic is used.
- A write is accepted when wr_en=1 and count < DEPTH, using pre-edge count. The word is stored at the write pointer and the write pointer advances. When wr_en=1 and count = DEPTH, the word is dropped, nothing changes, and overflow=1 in the next cycle.
- A read is accepted when rd_en=1 and count > 0, using pre-edge count. The read pointer advances. When rd_en=1 and count = 0, nothing is popped and underflow=1 in the next cycle.
- Simultaneous read and write:
  - Both are evaluated against pre-edge count.
  - If both are accepted, count is unchanged.
  - When full, the read is accepted and the write is dropped (overflow).
  - When empty, the write is accepted and the read fails (underflow). A word is never bypassed from write to read in the same cycle.
- count updates by +1 on a write only, -1 on a read only, and 0 on both or neither.
- almost_full, almost_empty and wr_ready are decoded combinationally from the count register.
- FWFT=0:
  - rd_data is a register loaded with the popped word on an accepted read.
  - rd_val is registered: 1 for exactly the cycle after an accepted read, otherwise 0.
  - rd_data holds its last value when no read is accepted.
- FWFT=1:
  - rd_val = (count ≠ 0).
  - rd_data = mem[read pointer] whenever rd_val=1. Its value while rd_val=0 carries no meaning.
  - Asserting rd_en while rd_val=1 pops the word; the next word appears after the edge.
- Reset:
  - Clears both pointers, count, rd_data, rd_val, overflow and underflow.
  - Reset outputs: wr_ready=1, almost_empty=1, and almost_full=0 (AFULL_LEVEL ≥ 1).
  - Reset overrides any concurrent rd_en/wr_en. Stored data is discarded mid-operation.
  - Memory contents are not cleared.

## Timing
- Write to count/flags: one edge. A word written at edge N is counted after N.
- Read latency, FWFT=0: rd_en sampled at edge N gives rd_data/rd_val valid during cycle N+1.
- Write to readable, FWFT=1: a word written at edge N into an empty FIFO shows rd_val=1 and rd_data in cycle N+1.
- overflow/underflow: one-cycle pulses, aligned with the cycle after the offending edge.
- Throughput: one write and one read per cycle sustained.

## Test plan
- DEPTH=5, FWFT=0:
  - Reset, then write 0x11..0x15 on 5 cycles: count 1..5, wr_ready=0 after the 5th, almost_full=1 at count 4. A 6th write of 0x16 gives overflow for one cycle and count stays 5.
  - From full, read 5 times: rd_data 0x11..0x15 each one cycle after rd_en with rd_val=1. A 6th read gives rd_val=0, underflow=1, count 0.
  - Wrap: 3 writes, 3 reads, then 4 writes and 4 reads. Data order is preserved across the pointer wrap at index 4 to 0.
  - Full with rd_en=wr_en=1 (0x20): the read returns the oldest word, overflow=1, count 5→4. Empty with both asserted (0x30): underflow=1, count 0→1, and a later read returns 0x30.
- DEPTH=5, FWFT=1: write 0xA5 to an empty FIFO: rd_val=1 and rd_data=0xA5 the next cycle without rd_en. Pop it: rd_val=0. A continuous rd_en+wr_en stream of 0x01,0x02,… yields an identical output stream with count constant.
- Reset asserted at count=3 with wr_en=1: the next cycle shows count=0, rd_val=0, wr_ready=1, almost_empty=1, and no overflow or underflow.
